ann_window_feeder: RTL and testbench
====================================

# ann_window_feeder

Upstream stage of the ANN temperature predictor. Accepts one daily temperature sample per handshake, keeps a 4-day sliding window plus the next day as training target, and drives the ANN input side. It sequences the ANN request/response exchange, latches the prediction, and optionally issues a one-cycle training pulse. One prediction per new sample once the window is primed.

## Interface
- DATA_W, 156, width of every temperature/data word (INPUT_SIZE*12)
- REQ_CYCLES, 5, cycles Rev_ready_h is held high per request (≥1)
- TIMEOUT, 1023, max cycles waiting for Ann_ready_h before error (≥1)
- Clk  in  1  single clock, rising edge
- Reset_l  in  1  asynchronous, active-low reset
- Flush_h  in  1  synchronous window clear (start of new year file)
- Train_mode_h  in  1  1: pulse training after each prediction
- Sample_in  in  DATA_W  daily temperature sample
- Sample_valid_h  in  1  Sample_in valid
- Sample_ready_h  out  1  feeder can accept a sample
- Temperature_out_0..3  out  DATA_W each  window, _0 oldest; to ANN Temperature_in_0..3
- Target_out  out  DATA_W  next-day sample; to ANN Target
- Rev_ready_h  out  1  to ANN tb_rev_ready_h
- Training_enable_h  out  1  to ANN training_enable_h
- Ann_ready_h  in  1  from ANN Ready_Signal
- Ann_data_in  in  DATA_W  from ANN Data_out
- Prediction_out  out  DATA_W  latched prediction
- Prediction_valid_h  out  1  one-cycle strobe with new Prediction_out
- Day_count  out  9  completed predictions since reset/flush, wraps mod 512
- Err_h  out  1  sticky timeout flag

## Operation
- States: FILL, WAIT_TARGET, ISSUE, WAIT_RESULT, TRAIN, SHIFT.
- Sample accepted when Sample_valid_h & Sample_ready_h; Sample_ready_h = (state FILL or WAIT_TARGET) & !Flush_h.
- FILL: accepted samples shift into window at _3 (older move toward _0); after 4th accept → WAIT_TARGET.
- WAIT_TARGET: accepted sample → Target_out; → ISSUE.
- ISSUE: Rev_ready_h=1 for exactly REQ_CYCLES cycles; → WAIT_RESULT.
- WAIT_RESULT: counter runs; Ann_ready_h=1 → latch Prediction_out, → TRAIN. Counter reaching TIMEOUT with Ann_ready_h=0 → Err_h=1, no prediction, → SHIFT.
- TRAIN: Prediction_valid_h=1, Training_enable_h=Train_mode_h (both 1 cycle), Day_count+1; window/target held; → SHIFT.
- SHIFT: window shifts left one, Target_out moves into _3; → WAIT_TARGET.
- Flush_h (any state): window, target, Day_count, Err_h, counters cleared; → FILL; pending pulses suppressed; sample not accepted that cycle.
- Ann_ready_h outside WAIT_RESULT ignored. Ann_ready_h and timeout in same cycle: Ann_ready_h wins.

## Timing
- Reset: all outputs 0, state FILL; Sample_ready_h rises first cycle after Reset_l deasserts.
- Sample accepted at edge t: visible on Temperature_out/Target_out from t+1.
- Target accepted at cycle c: Rev_ready_h high cycles c+1..c+REQ_CYCLES.
- Ann_ready_h seen cycle u: Prediction_out, Prediction_valid_h, Training_enable_h at u+1; Target_out stable through u+1; shifted window and Sample_ready_h=1 at u+3.
- Async reset mid-sequence: outputs 0 immediately, no partial pulse after release.

## Configuration
- ANN_FEEDER_SCALE_EN defined: Prediction_out = zero-extended Ann_data_in[25:0] / 1000 (integer, truncating).
- Undefined: Prediction_out = Ann_data_in unmodified.

## Structure
- Package ann_feeder_pkg: state enum, DATA_W default 156, SCALE_DIV=1000, Day_count width 9.
- Sub-module ann_sample_window: 4-deep shift register + target register with load/shift/clear controls; FSM, counters, scaling in top.

## Test plan
- Reset, feed 1,2,3,4,5 → Temperature_out_0..3=1,2,3,4, Target_out=5, Rev_ready_h high 5 cycles starting cycle after 5th accept.
- Ann_ready_h 3 cycles into WAIT_RESULT, Ann_data_in=25000, SCALE_EN, Train_mode_h=1 → Prediction_out=25, valid and Training_enable_h 1 cycle, Target_out=5 held, Day_count=1; feed 6 → window 2,3,4,5, target 6.
- Train_mode_h=0 → Prediction_valid_h pulses, Training_enable_h stays 0.
- Ann_ready_h never → after 1023 cycles Err_h=1 (sticky), no valid, Day_count unchanged, window shifts.
- Flush_h in WAIT_RESULT with Sample_valid_h=1 → FILL, Day_count=0, Err_h=0, sample rejected, no pulses.
- Reset_l low during ISSUE → Rev_ready_h and all outputs 0 same cycle; refill required.

Source files
------------

// File: rtl/ann_feeder_pkg.sv
// Shared types and constants for the ANN window feeder: FSM state encoding,
// default data width, prediction scaling divisor and day-counter width.
package ann_feeder_pkg;

  localparam int DATA_W_DEF = 156;
  localparam int SCALE_DIV  = 1000;
  localparam int SCALE_IN_W = 26;
  localparam int DAY_W      = 9;
  localparam int WIN_DEPTH  = 4;

  typedef enum logic [2:0] {
    S_FILL        = 3'd0,
    S_WAIT_TARGET = 3'd1,
    S_ISSUE       = 3'd2,
    S_WAIT_RESULT = 3'd3,
    S_TRAIN       = 3'd4,
    S_SHIFT       = 3'd5
  } feeder_state_e;

  // Raw ANN output is in milli-units; integer division truncates toward zero.
  function automatic logic [SCALE_IN_W-1:0] scale_div(input logic [SCALE_IN_W-1:0] raw);
    return raw / SCALE_IN_W'(SCALE_DIV);
  endfunction

endpackage

// File: rtl/ann_sample_window.sv
// Four-deep sliding window of daily samples plus the next-day target register.
// Slot 0 is the oldest; both push and shift move data toward slot 0.
module ann_sample_window
  import ann_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              shift_i,
  input  logic              target_load_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] win_o [WIN_DEPTH],
  output logic [DATA_W-1:0] target_o
);

  logic [DATA_W-1:0] win_q [WIN_DEPTH];
  logic [DATA_W-1:0] win_d [WIN_DEPTH];
  logic [DATA_W-1:0] target_q;
  logic [DATA_W-1:0] target_d;

  always_comb begin
    win_d    = win_q;
    target_d = target_q;
    if (clear_i) begin
      for (int i = 0; i < WIN_DEPTH; i++) win_d[i] = '0;
      target_d = '0;
    end else begin
      // A push brings in the fresh sample; a shift recycles the old target.
      if (push_i || shift_i) begin
        for (int i = 0; i < WIN_DEPTH - 1; i++) win_d[i] = win_q[i+1];
        win_d[WIN_DEPTH-1] = push_i ? sample_i : target_q;
      end
      if (target_load_i) target_d = sample_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= '0;
      target_q <= '0;
    end else begin
      win_q    <= win_d;
      target_q <= target_d;
    end
  end

  for (genvar gi = 0; gi < WIN_DEPTH; gi++) begin : g_out
    assign win_o[gi] = win_q[gi];
  end
  assign target_o = target_q;

endmodule

// File: rtl/ann_window_feeder.sv
// Feeds a 4-day temperature window and next-day target to the ANN, sequences the
// request/response exchange and latches predictions. Define ANN_FEEDER_SCALE_EN to divide by 1000.
module ann_window_feeder
  import ann_feeder_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REQ_CYCLES = 5,
  parameter int TIMEOUT    = 1023
) (
  input  logic              Clk,
  input  logic              Reset_l,
  input  logic              Flush_h,
  input  logic              Train_mode_h,
  input  logic [DATA_W-1:0] Sample_in,
  input  logic              Sample_valid_h,
  output logic              Sample_ready_h,
  output logic [DATA_W-1:0] Temperature_out_0,
  output logic [DATA_W-1:0] Temperature_out_1,
  output logic [DATA_W-1:0] Temperature_out_2,
  output logic [DATA_W-1:0] Temperature_out_3,
  output logic [DATA_W-1:0] Target_out,
  output logic              Rev_ready_h,
  output logic              Training_enable_h,
  input  logic              Ann_ready_h,
  input  logic [DATA_W-1:0] Ann_data_in,
  output logic [DATA_W-1:0] Prediction_out,
  output logic              Prediction_valid_h,
  output logic [DAY_W-1:0]  Day_count,
  output logic              Err_h
);

  localparam int REQ_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  feeder_state_e     state_q, state_d;
  logic [1:0]        fill_q, fill_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [DAY_W-1:0]  day_q, day_d;
  logic              err_q, err_d;
  logic              up_q, up_d;
  logic [DATA_W-1:0] pred_q, pred_d;
  logic [DATA_W-1:0] pred_raw;

  logic              accept;
  logic              win_clear, win_push, win_shift, tgt_load;
  logic [DATA_W-1:0] win [WIN_DEPTH];

`ifdef ANN_FEEDER_SCALE_EN
  logic unused_ann_hi;
  assign unused_ann_hi = ^Ann_data_in[DATA_W-1:SCALE_IN_W];
  assign pred_raw      = DATA_W'(scale_div(Ann_data_in[SCALE_IN_W-1:0]));
`else
  assign pred_raw = Ann_data_in;
`endif

  // up_q keeps Sample_ready_h low while reset is asserted and for the release cycle.
  assign Sample_ready_h = up_q && !Flush_h &&
                          (state_q == S_FILL || state_q == S_WAIT_TARGET);
  assign accept         = Sample_valid_h && Sample_ready_h;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    req_d     = req_q;
    wait_d    = wait_q;
    day_d     = day_q;
    err_d     = err_q;
    pred_d    = pred_q;
    up_d      = 1'b1;
    win_clear = 1'b0;
    win_push  = 1'b0;
    win_shift = 1'b0;
    tgt_load  = 1'b0;

    if (Flush_h) begin
      state_d   = S_FILL;
      fill_d    = '0;
      req_d     = '0;
      wait_d    = '0;
      day_d     = '0;
      err_d     = 1'b0;
      win_clear = 1'b1;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (accept) begin
            win_push = 1'b1;
            if (fill_q == 2'd3) begin
              fill_d  = '0;
              state_d = S_WAIT_TARGET;
            end else begin
              fill_d = fill_q + 2'd1;
            end
          end
        end
        S_WAIT_TARGET: begin
          if (accept) begin
            tgt_load = 1'b1;
            req_d    = '0;
            state_d  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_q == REQ_W'(REQ_CYCLES - 1)) begin
            req_d   = '0;
            wait_d  = '0;
            state_d = S_WAIT_RESULT;
          end else begin
            req_d = req_q + REQ_W'(1);
          end
        end
        S_WAIT_RESULT: begin
          // A response arriving on the final wait cycle still counts.
          if (Ann_ready_h) begin
            pred_d  = pred_raw;
            day_d   = day_q + DAY_W'(1);
            wait_d  = '0;
            state_d = S_TRAIN;
          end else if (wait_q == TO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = S_SHIFT;
          end else begin
            wait_d = wait_q + TO_W'(1);
          end
        end
        S_TRAIN: begin
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          win_shift = 1'b1;
          state_d   = S_WAIT_TARGET;
        end
        default: begin
          state_d = S_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_l) begin
    if (!Reset_l) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      req_q   <= '0;
      wait_q  <= '0;
      day_q   <= '0;
      err_q   <= 1'b0;
      up_q    <= 1'b0;
      pred_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      req_q   <= req_d;
      wait_q  <= wait_d;
      day_q   <= day_d;
      err_q   <= err_d;
      up_q    <= up_d;
      pred_q  <= pred_d;
    end
  end

  ann_sample_window #(
    .DATA_W (DATA_W)
  ) u_window (
    .clk           (Clk),
    .rst_n         (Reset_l),
    .clear_i       (win_clear),
    .push_i        (win_push),
    .shift_i       (win_shift),
    .target_load_i (tgt_load),
    .sample_i      (Sample_in),
    .win_o         (win),
    .target_o      (Target_out)
  );

  assign Temperature_out_0  = win[0];
  assign Temperature_out_1  = win[1];
  assign Temperature_out_2  = win[2];
  assign Temperature_out_3  = win[3];
  assign Rev_ready_h        = (state_q == S_ISSUE);
  // A flush in the TRAIN cycle swallows the strobes.
  assign Prediction_valid_h = (state_q == S_TRAIN) && !Flush_h;
  assign Training_enable_h  = Prediction_valid_h && Train_mode_h;
  assign Prediction_out     = pred_q;
  assign Day_count          = day_q;
  assign Err_h              = err_q;

endmodule

// File: tb/tb_ann_window_feeder.sv
// Directed bench for ann_window_feeder: priming, prediction with/without training,
// timeout, flush and async reset, with a prediction scoreboard queue.
module tb_ann_window_feeder;

  localparam int DATA_W     = 156;
  localparam int REQ_CYCLES = 5;
  localparam int TIMEOUT    = 1023;

  logic              Clk = 1'b0;
  logic              Reset_l = 1'b0;
  logic              Flush_h = 1'b0;
  logic              Train_mode_h = 1'b0;
  logic [DATA_W-1:0] Sample_in = '0;
  logic              Sample_valid_h = 1'b0;
  logic              Sample_ready_h;
  logic [DATA_W-1:0] Temperature_out_0, Temperature_out_1, Temperature_out_2, Temperature_out_3;
  logic [DATA_W-1:0] Target_out;
  logic              Rev_ready_h;
  logic              Training_enable_h;
  logic              Ann_ready_h = 1'b0;
  logic [DATA_W-1:0] Ann_data_in = '0;
  logic [DATA_W-1:0] Prediction_out;
  logic              Prediction_valid_h;
  logic [8:0]        Day_count;
  logic              Err_h;

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q [$];

  always #5 Clk = ~Clk;

  ann_window_feeder #(
    .DATA_W     (DATA_W),
    .REQ_CYCLES (REQ_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clk                (Clk),
    .Reset_l            (Reset_l),
    .Flush_h            (Flush_h),
    .Train_mode_h       (Train_mode_h),
    .Sample_in          (Sample_in),
    .Sample_valid_h     (Sample_valid_h),
    .Sample_ready_h     (Sample_ready_h),
    .Temperature_out_0  (Temperature_out_0),
    .Temperature_out_1  (Temperature_out_1),
    .Temperature_out_2  (Temperature_out_2),
    .Temperature_out_3  (Temperature_out_3),
    .Target_out         (Target_out),
    .Rev_ready_h        (Rev_ready_h),
    .Training_enable_h  (Training_enable_h),
    .Ann_ready_h        (Ann_ready_h),
    .Ann_data_in        (Ann_data_in),
    .Prediction_out     (Prediction_out),
    .Prediction_valid_h (Prediction_valid_h),
    .Day_count          (Day_count),
    .Err_h              (Err_h)
  );

  function automatic logic [DATA_W-1:0] model_pred(input logic [DATA_W-1:0] raw);
`ifdef ANN_FEEDER_SCALE_EN
    logic [25:0] lo;
    lo = raw[25:0];
    return DATA_W'(lo / 26'd1000);
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int a, input int b, input int c, input int d, input int t);
    chk({tag, "_w0"}, Temperature_out_0, DATA_W'(a));
    chk({tag, "_w1"}, Temperature_out_1, DATA_W'(b));
    chk({tag, "_w2"}, Temperature_out_2, DATA_W'(c));
    chk({tag, "_w3"}, Temperature_out_3, DATA_W'(d));
    chk({tag, "_tgt"}, Target_out, DATA_W'(t));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int v);
    int k;
    k = 0;
    Sample_in      = DATA_W'(v);
    Sample_valid_h = 1'b1;
    while (Sample_ready_h !== 1'b1 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    if (k == 50) chk("send_ready_timeout", Sample_ready_h, 1);
    step();
    Sample_valid_h = 1'b0;
    $display("send sample %0d after %0d wait cycles", v, k);
  endtask

  task automatic wait_rev_low();
    int k;
    k = 0;
    while (Rev_ready_h === 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (k == 20) chk("rev_low_timeout", Rev_ready_h, 0);
  endtask

  task automatic check_pred(input string tag, input logic exp_train, input int exp_day);
    logic [DATA_W-1:0] e;
    chk({tag, "_valid"}, Prediction_valid_h, 1);
    chk({tag, "_train"}, Training_enable_h, exp_train);
    chk({tag, "_day"}, Day_count, DATA_W'(exp_day));
    if (Prediction_valid_h === 1'b1) begin
      if (exp_q.size() == 0) chk({tag, "_unexpected"}, Prediction_valid_h, 0);
      else begin
        e = exp_q.pop_front();
        chk({tag, "_pred"}, Prediction_out, e);
      end
    end
    $display("prediction %s out=%0d day=%0d train=%0b", tag, Prediction_out, Day_count, Training_enable_h);
  endtask

  initial begin
    int n;
    int seen_valid;

    // Reset state
    #12;
    chk("rst_ready", Sample_ready_h, 0);
    chk("rst_rev", Rev_ready_h, 0);
    chk("rst_valid", Prediction_valid_h, 0);
    chk("rst_err", Err_h, 0);
    chk("rst_day", Day_count, 0);
    chk("rst_pred", Prediction_out, 0);
    chk_win("rst", 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset_l = 1'b1;
    #1;
    chk("rel_ready_lo", Sample_ready_h, 0);
    step();
    chk("rel_ready_hi", Sample_ready_h, 1);

    // Prime the window and issue the first request
    Train_mode_h = 1'b1;
    for (int i = 1; i <= 4; i++) send(i);
    chk_win("fill", 1, 2, 3, 4, 0);
    send(5);
    chk_win("primed", 1, 2, 3, 4, 5);
    for (int i = 0; i < REQ_CYCLES; i++) begin
      chk("rev_hi", Rev_ready_h, 1);
      step();
    end
    chk("rev_lo", Rev_ready_h, 0);

    // Response on the third WAIT_RESULT cycle
    step();
    step();
    Ann_ready_h = 1'b1;
    Ann_data_in = DATA_W'(25000);
    exp_q.push_back(model_pred(DATA_W'(25000)));
    step();
    Ann_ready_h = 1'b0;
    check_pred("p1", 1'b1, 1);
    chk("p1_tgt_held", Target_out, DATA_W'(5));
    chk("p1_ready", Sample_ready_h, 0);
    step();
    chk("p1_valid_off", Prediction_valid_h, 0);
    chk("p1_train_off", Training_enable_h, 0);
    chk_win("p1_noshift", 1, 2, 3, 4, 5);
    step();
    chk("p1_ready_back", Sample_ready_h, 1);
    chk_win("p1_shift", 2, 3, 4, 5, 5);
    send(6);
    chk_win("p1_feed6", 2, 3, 4, 5, 6);

    // Second prediction without training
    Train_mode_h = 1'b0;
    wait_rev_low();
    Ann_ready_h = 1'b1;
    Ann_data_in = DATA_W'(3000123);
    exp_q.push_back(model_pred(DATA_W'(3000123)));
    step();
    Ann_ready_h = 1'b0;
    check_pred("p2", 1'b0, 2);
    step();
    step();
    chk_win("p2_shift", 3, 4, 5, 6, 6);

    // Timeout: ANN never answers
    send(7);
    wait_rev_low();
    chk("to_err_pre", Err_h, 0);
    n = 0;
    seen_valid = 0;
    while (Err_h !== 1'b1 && n < 2000) begin
      step();
      n++;
      if (Prediction_valid_h === 1'b1) seen_valid++;
    end
    $display("timeout after %0d cycles in WAIT_RESULT", n);
    chk("to_cycles", DATA_W'(n), DATA_W'(TIMEOUT));
    chk("to_no_valid", DATA_W'(seen_valid), 0);
    chk("to_day", Day_count, DATA_W'(2));
    step();
    chk_win("to_shift", 4, 5, 6, 7, 7);
    chk("to_err_sticky", Err_h, 1);
    chk("to_ready", Sample_ready_h, 1);

    // Flush during WAIT_RESULT with a sample offered and a stray response
    send(8);
    wait_rev_low();
    Flush_h        = 1'b1;
    Sample_in      = DATA_W'(99);
    Sample_valid_h = 1'b1;
    Ann_ready_h    = 1'b1;
    #1;
    chk("fl_ready_blocked", Sample_ready_h, 0);
    step();
    Flush_h        = 1'b0;
    Sample_valid_h = 1'b0;
    Ann_ready_h    = 1'b0;
    #1;
    chk("fl_day", Day_count, 0);
    chk("fl_err", Err_h, 0);
    chk("fl_valid", Prediction_valid_h, 0);
    chk("fl_rev", Rev_ready_h, 0);
    chk("fl_ready", Sample_ready_h, 1);
    chk_win("fl", 0, 0, 0, 0, 0);
    step();
    chk("fl_valid2", Prediction_valid_h, 0);

    // Async reset during ISSUE
    for (int i = 11; i <= 15; i++) send(i);
    chk("ar_rev_pre", Rev_ready_h, 1);
    #2;
    Reset_l = 1'b0;
    #1;
    chk("ar_rev", Rev_ready_h, 0);
    chk("ar_ready", Sample_ready_h, 0);
    chk("ar_pred", Prediction_out, 0);
    chk_win("ar", 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset_l = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (Rev_ready_h === 1'b1 || Prediction_valid_h === 1'b1) seen_valid++;
    end
    chk("ar_no_pulse", DATA_W'(seen_valid), 0);
    chk("ar_refill_ready", Sample_ready_h, 1);
    chk("sb_empty", DATA_W'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
